ypbprtorgb: RTL and testbench
=============================

Name: ypbprtorgb

Overview:
- Multiplier-based YPbPr -> RGB converter; the decode-side inverse of the team's RGB -> YPbPr encoder.
- Accepts 6-bit component video (Y on the green lane, Pb on the blue lane, Pr on the red lane) with Pb/Pr offset-binary around 32.
- Produces clamped 6-bit RGB, plus sync/pixel strobes delayed to match.
- Sits between a component video source (capture or loopback test path) and RGB video consumers; has an ena-controlled passthrough mode.

Parameters:
- None. All coefficients are fixed. Data width is 6 bits in and 6 bits out.

Ports:
- clk  input  1  system/video clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ena  input  1  1 = convert; 0 = passthrough; sampled with each pixel
- red_in  input  6  Pr, offset-binary (32 = zero)
- green_in  input  6  Y, unsigned
- blue_in  input  6  Pb, offset-binary (32 = zero)
- hs_in  input  1  horizontal sync
- vs_in  input  1  vertical sync
- cs_in  input  1  composite sync
- pixel_in  input  1  pixel clock-enable strobe
- red_out  output  6  R
- green_out  output  6  G
- blue_out  output  6  B
- hs_out  output  1  delayed hs_in
- vs_out  output  1  delayed vs_in
- cs_out  output  1  delayed cs_in
- pixel_out  output  1  delayed pixel_in

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- While reset=1, every pipeline register, including the delayed ena, clears to 0 at the clock edge. From the edge after reset is asserted, all outputs read 0.
- Reset clears everything in flight. The first output derived from post-reset input appears 3 cycles after the first post-reset sampling edge.
- Latency is fixed at 3 clk cycles for data, ena mode and the four strobes. Strobes take no part in arithmetic.
- Stage 1 (edge 1):
  - Register Ys = green_in * 256 (14-bit unsigned).
  - Register Pb' = blue_in - 32 and Pr' = red_in - 32 (7-bit signed, range -32..31).
  - Register ena and the raw inputs alongside.
- Stage 2 (edge 2): register the signed products:
  - Pr'*359 (1.402)
  - Pb'*88 (0.344)
  - Pr'*183 (0.714)
  - Pb'*454 (1.772)
  - Ys is carried forward unchanged.
  - Products must be at least 15 bits signed.
- Stage 3 (edge 3): form the signed 17-bit sums:
  - R = Ys + Pr'*359 + 128
  - G = Ys - Pb'*88 - Pr'*183 + 128
  - B = Ys + Pb'*454 + 128
  - The +128 rounds to nearest.
- Clamp each sum:
  - sum < 0 -> 0
  - sum >= 64*256 -> 63
  - otherwise -> sum[13:8]
  - Register the clamped value to the output.
- Passthrough: when the ena value delayed with a pixel is 0, that pixel's outputs are red_out=red_in, green_out=green_in, blue_out=blue_in, with the same 3-cycle latency and no offset or clamp applied.
- ena may toggle on any cycle. Mode follows the data through the pipeline, so no output ever mixes modes and no output glitches.
- No handshake or stall. The pipeline advances every clk. pixel_in only tags data and does not gate the registers.
- Arithmetic must not wrap at any input:
  - extreme R sum: 16128 + 11129 + 128 = 27385
  - extreme B sum: 0 - 14528 + 128 = -14400
  - both must fit the 17-bit signed sums.

Test Plan:
- Black and white: with ena=1, hold (Y,Pb,Pr)=(0,32,32), then (63,32,32). RGB is (0,0,0), then (63,63,63), each exactly 3 cycles after the input.
- Red overdrive clamp: with ena=1, apply (Y,Pb,Pr)=(32,32,63). Output is R=63 (clamped from 75), G=10, B=32.
- Negative clamp: with ena=1, apply (Y,Pb,Pr)=(0,0,32). Output is R=0, G=11, B=0 (clamped from negative).
- Passthrough and mode switch: ena=0 with inputs (red,green,blue)=(5,40,17) gives outputs (5,40,17) after 3 cycles. Toggle ena every cycle with differing data; each output cycle matches the mode of its own input cycle, with no mixed values.
- Sync alignment: pulse hs_in, vs_in, cs_in and pixel_in on distinct cycles. Each output strobe reproduces its pulse delayed by exactly 3 cycles, with width preserved.
- Reset mid-stream: assert reset for 1 cycle during continuous data. All outputs are 0 from the next edge until valid data re-emerges 3 cycles after the first post-reset input; no stale pre-reset pixel ever appears.

Source files
------------

// File: rtl/ypbprtorgb_if.sv
// Component-video bundle for the YPbPr -> RGB converter: ena, YPbPr and strobes in,
// and RGB plus delayed strobes out.
interface ypbprtorgb_if;
  logic       ena;
  logic [5:0] red_in;
  logic [5:0] green_in;
  logic [5:0] blue_in;
  logic       hs_in;
  logic       vs_in;
  logic       cs_in;
  logic       pixel_in;
  logic [5:0] red_out;
  logic [5:0] green_out;
  logic [5:0] blue_out;
  logic       hs_out;
  logic       vs_out;
  logic       cs_out;
  logic       pixel_out;

  modport slave (
    input  ena, red_in, green_in, blue_in, hs_in, vs_in, cs_in, pixel_in,
    output red_out, green_out, blue_out, hs_out, vs_out, cs_out, pixel_out
  );

  modport master (
    output ena, red_in, green_in, blue_in, hs_in, vs_in, cs_in, pixel_in,
    input  red_out, green_out, blue_out, hs_out, vs_out, cs_out, pixel_out
  );
endinterface

// File: rtl/ypbprtorgb.sv
// 3-stage multiplier-based YPbPr -> RGB converter with clamping, an ena-selected
// passthrough path, and sync/pixel strobes delayed to stay aligned with the data.
module ypbprtorgb (
  input  logic          clk,
  input  logic          reset,
  ypbprtorgb_if.slave   bus
);

  logic        [13:0] ys1_q, ys1_d, ys2_q;
  logic signed [6:0]  pb1_q, pb1_d, pr1_q, pr1_d;
  logic        [17:0] raw1_q, raw2_q;
  logic               ena1_q, ena2_q;
  logic        [3:0]  stb1_q, stb2_q, stb3_q;
  logic signed [15:0] pb_ext, pr_ext;
  logic signed [15:0] pr359_q, pr359_d, pb88_q, pb88_d;
  logic signed [15:0] pr183_q, pr183_d, pb454_q, pb454_d;
  logic        [16:0] sum_r, sum_g, sum_b, ys_ext;
  logic        [5:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  // Negative sums clamp to 0; anything at or above 64*256 saturates to 63.
  function automatic logic [5:0] clamp6(input logic [16:0] s);
    if (s[16])
      return '0;
    else if (s[15:14] != 2'b00)
      return '1;
    else
      return s[13:8];
  endfunction

  always_comb begin
    ys1_d = {bus.green_in, 8'h00};
    pb1_d = {1'b0, bus.blue_in} - 7'd32;
    pr1_d = {1'b0, bus.red_in} - 7'd32;

    pb_ext  = {{9{pb1_q[6]}}, pb1_q};
    pr_ext  = {{9{pr1_q[6]}}, pr1_q};
    pr359_d = pr_ext * 16'sd359;
    pb88_d  = pb_ext * 16'sd88;
    pr183_d = pr_ext * 16'sd183;
    pb454_d = pb_ext * 16'sd454;

    ys_ext = {3'b000, ys2_q};
    sum_r  = ys_ext + {pr359_q[15], pr359_q} + 17'd128;
    sum_g  = ys_ext - {pb88_q[15], pb88_q} - {pr183_q[15], pr183_q} + 17'd128;
    sum_b  = ys_ext + {pb454_q[15], pb454_q} + 17'd128;

    // Mode travels with the pixel, so the select uses the ena carried through stage 2.
    if (ena2_q) begin
      r_d = clamp6(sum_r);
      g_d = clamp6(sum_g);
      b_d = clamp6(sum_b);
    end else begin
      r_d = raw2_q[17:12];
      g_d = raw2_q[11:6];
      b_d = raw2_q[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ys1_q   <= '0;
      pb1_q   <= '0;
      pr1_q   <= '0;
      raw1_q  <= '0;
      ena1_q  <= 1'b0;
      stb1_q  <= '0;
      ys2_q   <= '0;
      pr359_q <= '0;
      pb88_q  <= '0;
      pr183_q <= '0;
      pb454_q <= '0;
      raw2_q  <= '0;
      ena2_q  <= 1'b0;
      stb2_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      stb3_q  <= '0;
    end else begin
      ys1_q   <= ys1_d;
      pb1_q   <= pb1_d;
      pr1_q   <= pr1_d;
      raw1_q  <= {bus.red_in, bus.green_in, bus.blue_in};
      ena1_q  <= bus.ena;
      stb1_q  <= {bus.hs_in, bus.vs_in, bus.cs_in, bus.pixel_in};
      ys2_q   <= ys1_q;
      pr359_q <= pr359_d;
      pb88_q  <= pb88_d;
      pr183_q <= pr183_d;
      pb454_q <= pb454_d;
      raw2_q  <= raw1_q;
      ena2_q  <= ena1_q;
      stb2_q  <= stb1_q;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      stb3_q  <= stb2_q;
    end
  end

  assign bus.red_out   = r_q;
  assign bus.green_out = g_q;
  assign bus.blue_out  = b_q;
  assign bus.hs_out    = stb3_q[3];
  assign bus.vs_out    = stb3_q[2];
  assign bus.cs_out    = stb3_q[1];
  assign bus.pixel_out = stb3_q[0];

endmodule

// File: tb/tb_ypbprtorgb.sv
// Scoreboard bench for ypbprtorgb: each sampled input pushes its expected output,
// which is popped and compared three clocks later.
module tb_ypbprtorgb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ypbprtorgb_if bus();

  ypbprtorgb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic [3:0] stb;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_pop;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input int s);
    if (s < 0) return 0;
    if (s >= 16384) return 63;
    return s / 256;
  endfunction

  function automatic exp_t model(input logic en, input int pr, input int y, input int pb,
                                 input logic [3:0] stb);
    exp_t x;
    int ys, pbs, prs;
    ys  = y * 256;
    pbs = pb - 32;
    prs = pr - 32;
    if (en) begin
      x.r = 6'(clamp_ref(ys + prs * 359 + 128));
      x.g = 6'(clamp_ref(ys - pbs * 88 - prs * 183 + 128));
      x.b = 6'(clamp_ref(ys + pbs * 454 + 128));
    end else begin
      x.r = 6'(pr);
      x.g = 6'(y);
      x.b = 6'(pb);
    end
    x.stb = stb;
    return x;
  endfunction

  // A reset edge empties the pipe: the next three outputs are zero.
  always @(posedge clk) begin
    if (reset) begin
      sb_q.delete();
      repeat (3) sb_q.push_back('0);
    end else begin
      sb_q.push_back(model(bus.ena, int'(bus.red_in), int'(bus.green_in), int'(bus.blue_in),
                           {bus.hs_in, bus.vs_in, bus.cs_in, bus.pixel_in}));
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() == 3) begin
      e_pop = sb_q.pop_front();
      check_eq("red",   int'(bus.red_out),   int'(e_pop.r));
      check_eq("green", int'(bus.green_out), int'(e_pop.g));
      check_eq("blue",  int'(bus.blue_out),  int'(e_pop.b));
      check_eq("strobes", int'({bus.hs_out, bus.vs_out, bus.cs_out, bus.pixel_out}),
               int'(e_pop.stb));
    end
  end

  task automatic drive(input logic en, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input logic [3:0] stb);
    bus.ena      = en;
    bus.red_in   = r;
    bus.green_in = g;
    bus.blue_in  = b;
    {bus.hs_in, bus.vs_in, bus.cs_in, bus.pixel_in} = stb;
    @(posedge clk);
    #1;
  endtask

  // Hold one pixel for three clocks, then check the literal expected RGB.
  task automatic hold_check(input string tag, input logic en, input logic [5:0] r,
                            input logic [5:0] g, input logic [5:0] b,
                            input int er, input int eg, input int eb);
    repeat (3) drive(en, r, g, b, 4'b0000);
    check_eq({tag, "_r"}, int'(bus.red_out),   er);
    check_eq({tag, "_g"}, int'(bus.green_out), eg);
    check_eq({tag, "_b"}, int'(bus.blue_out),  eb);
  endtask

  initial begin
    bus.ena = 1'b0;
    bus.red_in = '0;
    bus.green_in = '0;
    bus.blue_in = '0;
    {bus.hs_in, bus.vs_in, bus.cs_in, bus.pixel_in} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_r", int'(bus.red_out), 0);
    check_eq("reset_stb", int'({bus.hs_out, bus.vs_out, bus.cs_out, bus.pixel_out}), 0);
    reset = 1'b0;

    hold_check("black", 1'b1, 6'd32, 6'd0,  6'd32, 0, 0, 0);
    hold_check("white", 1'b1, 6'd32, 6'd63, 6'd32, 63, 63, 63);
    hold_check("red_clamp", 1'b1, 6'd63, 6'd32, 6'd32, 63, 10, 32);
    hold_check("neg_clamp", 1'b1, 6'd32, 6'd0, 6'd0, 0, 11, 0);
    hold_check("pass", 1'b0, 6'd5, 6'd40, 6'd17, 5, 40, 17);

    for (int unsigned i = 0; i < 24; i++)
      drive(i[0], 6'($urandom), 6'($urandom), 6'($urandom), 4'b0000);

    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned w = 0; w <= k; w++)
        drive(1'b1, 6'd32, 6'd20, 6'd32, 4'(4'b1000 >> k));
      repeat (2) drive(1'b1, 6'd32, 6'd20, 6'd32, 4'b0000);
    end

    for (int unsigned i = 0; i < 30; i++) begin
      reset = (i == 12);
      drive(1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
    end
    reset = 1'b0;

    for (int unsigned i = 0; i < 200; i++)
      drive(1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));

    repeat (4) drive(1'b0, '0, '0, '0, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
